// File: rtl/branch_ckpt_ctrl.sv
// Rename-stage branch checkpoint scheduler: allocates checkpoint slots to
// dispatching branches, retires them in order as they resolve, and sequences
// mispredict recovery (one restore pulse, then a timed flush window).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | normal operation, dispatch allowed when ring not full
// RESTORE | restore pulse for recover_id, flush asserted, rename stalled
// FLUSH   | flush window counting down, rename stalled
module branch_ckpt_ctrl #(
  parameter int CKPT_WIDTH     = 2,
  parameter int ROB_WIDTH      = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_dispatch_valid,
  input  logic [ROB_WIDTH-1:0]  br_rob_tag,
  output logic [CKPT_WIDTH-1:0] ckpt_alloc_id,
  output logic                  ckpt_alloc_grant,
  input  logic                  br_resolve_valid,
  input  logic [CKPT_WIDTH-1:0] br_resolve_id,
  input  logic                  br_resolve_mispredict,
  output logic                  recover_valid,
  output logic [CKPT_WIDTH-1:0] recover_id,
  output logic [ROB_WIDTH-1:0]  recover_rob_tag,
  output logic                  flush,
  output logic                  rename_stall,
  output logic [CKPT_WIDTH:0]   ckpt_count
);

  localparam int SLOTS = 1 << CKPT_WIDTH;
  localparam int FC_W  = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t                state;
  logic [FC_W-1:0]       flush_cnt;
  logic                  ent_valid    [SLOTS];
  logic                  ent_resolved [SLOTS];
  logic [ROB_WIDTH-1:0]  ent_tag      [SLOTS];
  logic [CKPT_WIDTH-1:0] head;
  logic [CKPT_WIDTH-1:0] tail;
  logic [CKPT_WIDTH:0]   count;

  logic                  mp_now;
  logic                  resolve_ok;
  logic                  retire;
  logic                  ckpt_full;
  logic [CKPT_WIDTH-1:0] mp_dist;
  logic                  kill [SLOTS];

  // Resolve classification, retire decision and recovery kill mask.
  always_comb begin
    logic [CKPT_WIDTH-1:0] dist_i;
    dist_i     = '0;
    mp_now     = br_resolve_valid & br_resolve_mispredict & ent_valid[br_resolve_id];
    resolve_ok = br_resolve_valid & ~br_resolve_mispredict & ent_valid[br_resolve_id];
    // A correct resolve of the head retires in the same cycle; a mispredict on
    // the head wipes it instead, so no retire then.
    retire     = ent_valid[head]
               & (ent_resolved[head] | (resolve_ok & (br_resolve_id == head)))
               & ~(mp_now & (br_resolve_id == head));
    ckpt_full  = (count == (CKPT_WIDTH+1)'(SLOTS));
    mp_dist    = br_resolve_id - head;
    for (int i = 0; i < SLOTS; i++) begin
      dist_i  = CKPT_WIDTH'(i) - head;
      kill[i] = mp_now & ent_valid[i] & (dist_i >= mp_dist);
    end
  end

  // Backpressure and grant; full check deliberately uses registered count.
  always_comb begin
    rename_stall     = ckpt_full | (state != IDLE) | mp_now;
    ckpt_alloc_grant = br_dispatch_valid & ~rename_stall;
    ckpt_alloc_id    = tail;
    ckpt_count       = count;
  end

  // Checkpoint ring: allocation, resolve marking, in-order retire, truncation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        ent_valid[i]    <= 1'b0;
        ent_resolved[i] <= 1'b0;
        ent_tag[i]      <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (resolve_ok)
        ent_resolved[br_resolve_id] <= 1'b1;
      if (retire) begin
        ent_valid[head]    <= 1'b0;
        ent_resolved[head] <= 1'b0;
        head               <= head + 1'b1;
      end
      if (mp_now) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (kill[i]) begin
            ent_valid[i]    <= 1'b0;
            ent_resolved[i] <= 1'b0;
          end
        end
        tail  <= br_resolve_id;
        count <= {1'b0, mp_dist} - (CKPT_WIDTH+1)'(retire);
      end else begin
        if (ckpt_alloc_grant) begin
          ent_valid[tail]    <= 1'b1;
          ent_resolved[tail] <= 1'b0;
          ent_tag[tail]      <= br_rob_tag;
          tail               <= tail + 1'b1;
        end
        count <= count + (CKPT_WIDTH+1)'(ckpt_alloc_grant) - (CKPT_WIDTH+1)'(retire);
      end
    end
  end

  // Recovery sequencer with registered restore/flush outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      flush_cnt       <= '0;
      recover_valid   <= 1'b0;
      flush           <= 1'b0;
      recover_id      <= '0;
      recover_rob_tag <= '0;
    end else if (mp_now) begin
      // Any live mispredict (re)starts recovery; live entries are always older
      // than an in-progress recovery point.
      state           <= RESTORE;
      recover_valid   <= 1'b1;
      flush           <= 1'b1;
      recover_id      <= br_resolve_id;
      recover_rob_tag <= ent_tag[br_resolve_id];
    end else begin
      case (state)
        RESTORE: begin
          state         <= FLUSH;
          flush_cnt     <= FC_W'(RECOVER_CYCLES);
          recover_valid <= 1'b0;
          flush         <= 1'b1;
        end
        FLUSH: begin
          recover_valid <= 1'b0;
          if (flush_cnt <= FC_W'(1)) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          recover_valid <= 1'b0;
          flush         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed, table-driven bench for branch_ckpt_ctrl. Each row holds the inputs
// for one cycle and the outputs expected in that same cycle (registered state
// before the next edge plus the combinational response to the row's inputs).
module tb_branch_ckpt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_dispatch_valid;
  logic [3:0] br_rob_tag;
  logic [1:0] ckpt_alloc_id;
  logic       ckpt_alloc_grant;
  logic       br_resolve_valid;
  logic [1:0] br_resolve_id;
  logic       br_resolve_mispredict;
  logic       recover_valid;
  logic [1:0] recover_id;
  logic [3:0] recover_rob_tag;
  logic       flush;
  logic       rename_stall;
  logic [2:0] ckpt_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_ckpt_ctrl #(.CKPT_WIDTH(2), .ROB_WIDTH(4), .RECOVER_CYCLES(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .br_dispatch_valid     (br_dispatch_valid),
    .br_rob_tag            (br_rob_tag),
    .ckpt_alloc_id         (ckpt_alloc_id),
    .ckpt_alloc_grant      (ckpt_alloc_grant),
    .br_resolve_valid      (br_resolve_valid),
    .br_resolve_id         (br_resolve_id),
    .br_resolve_mispredict (br_resolve_mispredict),
    .recover_valid         (recover_valid),
    .recover_id            (recover_id),
    .recover_rob_tag       (recover_rob_tag),
    .flush                 (flush),
    .rename_stall          (rename_stall),
    .ckpt_count            (ckpt_count)
  );

  typedef struct {
    int d, tag, rv, rid, mp;
    int g, aid, st, cnt, rvl, rido, rtag, fl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, tag, rv, rid, mp,
                     input int g, aid, st, cnt, rvl, rido, rtag, fl);
    vec_t v;
    v = '{d, tag, rv, rid, mp, g, aid, st, cnt, rvl, rido, rtag, fl};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string p, input vec_t v);
    check({p, " grant"},     int'(ckpt_alloc_grant), v.g);
    check({p, " alloc_id"},  int'(ckpt_alloc_id),    v.aid);
    check({p, " stall"},     int'(rename_stall),     v.st);
    check({p, " count"},     int'(ckpt_count),       v.cnt);
    check({p, " rec_valid"}, int'(recover_valid),    v.rvl);
    check({p, " rec_id"},    int'(recover_id),       v.rido);
    check({p, " rec_tag"},   int'(recover_rob_tag),  v.rtag);
    check({p, " flush"},     int'(flush),            v.fl);
  endtask

  task automatic drive(input int d, tag, rv, rid, mp);
    br_dispatch_valid     = d[0];
    br_rob_tag            = tag[3:0];
    br_resolve_valid      = rv[0];
    br_resolve_id         = rid[1:0];
    br_resolve_mispredict = mp[0];
  endtask

  initial begin
    //   d tag rv rid mp |  g aid st cnt rvl rid rtag fl
    // reset state, fill ring with tags 3..6, overflow attempt
    add(0, 0, 0,0,0,  0,0,0,0, 0,0,0,0);
    add(1, 3, 0,0,0,  1,0,0,0, 0,0,0,0);
    add(1, 4, 0,0,0,  1,1,0,1, 0,0,0,0);
    add(1, 5, 0,0,0,  1,2,0,2, 0,0,0,0);
    add(1, 6, 0,0,0,  1,3,0,3, 0,0,0,0);
    add(1, 7, 0,0,0,  0,0,1,4, 0,0,0,0);
    // full ring: resolve id0 correct, same-cycle dispatch refused, then wraps to id0
    add(1, 7, 1,0,0,  0,0,1,4, 0,0,0,0);
    add(1, 7, 0,0,0,  1,0,0,3, 0,0,0,0);
    // drain ids 1..3, then live ids 0(7),1(8),2(9)
    add(0, 0, 1,1,0,  0,1,1,4, 0,0,0,0);
    add(0, 0, 1,2,0,  0,1,0,3, 0,0,0,0);
    add(0, 0, 1,3,0,  0,1,0,2, 0,0,0,0);
    add(1, 8, 0,0,0,  1,1,0,1, 0,0,0,0);
    add(1, 9, 0,0,0,  1,2,0,2, 0,0,0,0);
    // mispredict id1 at N; restore N+1, flush N+1..N+3, grant at N+4
    add(0, 0, 1,1,1,  0,3,1,3, 0,0,0,0);
    add(0, 0, 0,0,0,  0,1,1,1, 1,1,8,1);
    add(0, 0, 0,0,0,  0,1,1,1, 0,1,8,1);
    add(0, 0, 0,0,0,  0,1,1,1, 0,1,8,1);
    add(1,10, 0,0,0,  1,1,0,1, 0,1,8,0);
    add(1,11, 0,0,0,  1,2,0,2, 0,1,8,0);
    // mispredict id2 with dispatch, then nested mispredict id0 during FLUSH
    add(1,12, 1,2,1,  0,3,1,3, 0,1,8,0);
    add(0, 0, 0,0,0,  0,2,1,2, 1,2,11,1);
    add(0, 0, 1,0,1,  0,2,1,2, 0,2,11,1);
    add(0, 0, 0,0,0,  0,0,1,0, 1,0,7,1);
    add(0, 0, 0,0,0,  0,0,1,0, 0,0,7,1);
    add(0, 0, 0,0,0,  0,0,1,0, 0,0,7,1);
    add(0, 0, 0,0,0,  0,0,0,0, 0,0,7,0);
    // resolves to invalid ids are ignored
    add(0, 0, 1,3,1,  0,0,0,0, 0,0,7,0);
    add(0, 0, 1,2,0,  0,0,0,0, 0,0,7,0);
    add(1,13, 0,0,0,  1,0,0,0, 0,0,7,0);
    add(1,14, 1,3,1,  1,1,0,1, 0,0,7,0);
    // enter recovery again to set up reset-during-FLUSH
    add(0, 0, 1,1,1,  0,2,1,2, 0,0,7,0);
    add(0, 0, 0,0,0,  0,1,1,1, 1,1,14,1);
    add(0, 0, 0,0,0,  0,1,1,1, 0,1,14,1);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].d, vecs[i].tag, vecs[i].rv, vecs[i].rid, vecs[i].mp);
      #1;
      check_all($sformatf("row%0d", i), vecs[i]);
    end

    // Reset asserted while still in FLUSH: everything clears immediately.
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("pre_reset flush", int'(flush), 1);
    reset = 1'b0;
    #1;
    check("rst flush",     int'(flush),            0);
    check("rst stall",     int'(rename_stall),     0);
    check("rst rec_valid", int'(recover_valid),    0);
    check("rst rec_id",    int'(recover_id),       0);
    check("rst rec_tag",   int'(recover_rob_tag),  0);
    check("rst count",     int'(ckpt_count),       0);
    check("rst alloc_id",  int'(ckpt_alloc_id),    0);
    check("rst grant",     int'(ckpt_alloc_grant), 0);
    #2;
    reset = 1'b1;
    drive(1, 15, 0, 0, 0);
    #1;
    check("post_rst grant",    int'(ckpt_alloc_grant), 1);
    check("post_rst alloc_id", int'(ckpt_alloc_id),    0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    check("post_rst count",    int'(ckpt_count),    1);
    check("post_rst alloc_id2", int'(ckpt_alloc_id), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
